// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial operand path (loader and downstream deserializer).
package serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Cycles per word beyond the WIDTH shift cycles: CLEAR, DONE and the IDLE handshake cycle.
    localparam int unsigned FRAME_OVERHEAD = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic xfer(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for serial framing: synchronous load-to-zero, enable, terminal flag.
module serial_bit_counter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CW = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_operand_loader.sv
// Accepts a parallel operand pair plus carry-in and streams it LSB-first to a bit-serial adder.
module serial_operand_loader
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             add_clr,
    output logic             a,
    output logic             b,
    output logic             cin,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic             cin_q, cin_d;
    logic             add_clr_q, add_clr_d;
    logic             a_q, a_d, b_q, b_d;
    logic             bit_valid_q, bit_valid_d;
    logic             first_bit_q, first_bit_d;
    logic             last_bit_q, last_bit_d;
    logic             done_q, done_d;
    logic             take;
    logic             cnt_load, cnt_en, cnt_last;
    logic [CW-1:0]    cnt;

    serial_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (cnt),
        .last  (cnt_last)
    );

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cin_d    = cin_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        take     = xfer(in_valid, in_ready);

        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = CLEAR;
                    sa_d    = in_a;
                    sb_d    = in_b;
                    cin_d   = in_cin;
                end
            end
            CLEAR: begin
                state_d  = SHIFT;
                cnt_load = 1'b1;
            end
            SHIFT: begin
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                if (cnt_last) begin
                    state_d  = DONE;
                    cnt_load = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            cin_d = 1'b0;
        end

        // Outputs are registered copies of what the next state will present, so they
        // line up with state_q without any combinational decode on the output side.
        add_clr_d   = (state_d == CLEAR);
        bit_valid_d = (state_d == SHIFT);
        a_d         = bit_valid_d && sa_d[0];
        b_d         = bit_valid_d && sb_d[0];
        first_bit_d = (state_q == CLEAR);
        last_bit_d  = (state_q == SHIFT) && (cnt == PENULT);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            cin_q       <= 1'b0;
            add_clr_q   <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            first_bit_q <= 1'b0;
            last_bit_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            cin_q       <= cin_d;
            add_clr_q   <= add_clr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bit_valid_q <= bit_valid_d;
            first_bit_q <= first_bit_d;
            last_bit_q  <= last_bit_d;
            done_q      <= done_d;
        end
    end

    assign add_clr   = add_clr_q;
    assign a         = a_q;
    assign b         = b_q;
    assign cin       = cin_q;
    assign bit_valid = bit_valid_q;
    assign first_bit = first_bit_q;
    assign last_bit  = last_bit_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_operand_loader.sv
// Bench for serial_operand_loader: per-cycle expectations from a transfer-time offset model.
module tb_serial_operand_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_cin;
    logic         add_clr, a, b, cin, bit_valid, first_bit, last_bit, done;

    serial_operand_loader #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_clr   (add_clr),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .bit_valid (bit_valid),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: the edge index of the last accepted transfer and the captured word.
    int           e     = 0;
    int           t     = 0;
    logic         have  = 1'b0;
    int           xfers = 0;
    logic [W-1:0] ma, mb;
    logic         mc;

    // Behavioural serial adder fed from the observed DUT outputs.
    logic [W-1:0] acc;
    logic         cy;
    int           nb;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h at edge %0d", tag, obs, exp, e);
        end
    endtask

    task automatic check_all();
        int           off;
        logic         act, sh_on;
        logic [W-1:0] sha, shb;
        logic [15:0]  want;
        off   = e - t;
        act   = have && off >= 0 && off <= W + 1;
        sh_on = act && off >= 1 && off <= W;
        sha   = '0;
        shb   = '0;
        if (sh_on) begin
            sha = ma >> (off - 1);
            shb = mb >> (off - 1);
        end
        chk("in_ready",  16'(in_ready),  16'(!act));
        chk("add_clr",   16'(add_clr),   16'(act && off == 0));
        chk("bit_valid", 16'(bit_valid), 16'(sh_on));
        chk("a",         16'(a),         16'(sha[0]));
        chk("b",         16'(b),         16'(shb[0]));
        chk("cin",       16'(cin),       16'(act ? mc : 1'b0));
        chk("first_bit", 16'(first_bit), 16'(act && off == 1));
        chk("last_bit",  16'(last_bit),  16'(act && off == W));
        chk("done",      16'(done),      16'(act && off == W + 1));

        if (add_clr) begin
            acc = '0;
            cy  = cin;
            nb  = 0;
        end
        if (bit_valid && nb < W) begin
            acc[nb] = a ^ b ^ cy;
            cy      = (a & b) | (a & cy) | (b & cy);
            nb++;
        end
        if (done) begin
            want = 16'(ma) + 16'(mb) + 16'(mc);
            chk("adder_sum", {7'd0, cy, acc}, want);
        end
    endtask

    task automatic step();
        logic rdy;
        rdy = !have || (e - t >= W + 2);
        @(posedge clk);
        e++;
        if (reset) begin
            have = 1'b0;
        end else if (in_valid && rdy) begin
            have = 1'b1;
            t    = e;
            ma   = in_a;
            mb   = in_b;
            mc   = in_cin;
            xfers++;
        end
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        int n0;
        n0       = xfers;
        in_valid = 1'b1;
        in_a     = va;
        in_b     = vb;
        in_cin   = vc;
        for (int i = 0; i < 4 * W && xfers == n0; i++) step();
        if (xfers == n0) chk("xfer_timeout", 16'd0, 16'd1);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
    endtask

    task automatic finish_word();
        for (int i = 0; i < W + 2; i++) step();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_cin   = 1'b0;
        acc      = '0;
        cy       = 1'b0;
        nb       = 0;

        // Reset held three cycles, even with in_valid offered.
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Directed word: B5 + 3C + 1 = F2, carry 0.
        send_word(8'hB5, 8'h3C, 1'b1);
        finish_word();
        chk("sum_B5_3C", {7'd0, cy, acc}, 16'h00F2);
        step();

        // in_valid with new data mid-SHIFT is ignored; the source holds it until in_ready.
        send_word(8'h5A, 8'hC3, 1'b0);
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b1;
        in_a     = 8'h77;
        in_b     = 8'h19;
        in_cin   = 1'b1;
        step();
        chk("busy_ready", 16'(in_ready), 16'd0);
        send_word(8'h77, 8'h19, 1'b1);
        finish_word();
        chk("sum_77_19", {7'd0, cy, acc}, 16'h0091);

        // All-ones plus one: result 00 with carry out.
        send_word(8'hFF, 8'h01, 1'b0);
        finish_word();
        chk("sum_FF_01", {7'd0, cy, acc}, 16'h0100);

        // Asynchronous reset during the fourth bit aborts the word without done.
        send_word(8'hA7, 8'h6E, 1'b1);
        for (int i = 0; i < 4; i++) step();
        #1;
        reset = 1'b1;
        have  = 1'b0;
        #1;
        check_all();
        step();
        step();
        reset = 1'b0;
        step();
        send_word(8'h3D, 8'h92, 1'b0);
        finish_word();
        chk("sum_after_rst", {7'd0, cy, acc}, 16'h00CF);

        // Back-to-back: in_valid held, next operands presented right after each accept.
        begin
            int n0;
            n0       = xfers;
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom);
            for (int i = 0; i < 4 * (W + 3) + 1; i++) begin
                int nb4;
                nb4 = xfers;
                step();
                if (xfers != nb4) begin
                    in_a   = W'($urandom);
                    in_b   = W'($urandom);
                    in_cin = 1'($urandom);
                end
            end
            in_valid = 1'b0;
            chk("b2b_count", 16'(xfers - n0), 16'd5);
            finish_word();
            step();
        end

        // Randomized words with random idle gaps and spurious in_valid while busy.
        for (int k = 0; k < 12; k++) begin
            send_word(W'($urandom), W'($urandom), 1'($urandom));
            for (int i = 0; i < W + 2; i++) begin
                in_valid = ($urandom_range(0, 3) == 0);
                if (e - t >= W + 1) in_valid = 1'b0;
                step();
            end
            in_valid = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
